// File: rtl/my_fp_to_int.sv
// Pipelined float-to-signed-integer converter: unpack/classify, align, round/saturate.
// Valid-only stream, one word per clock, three clocks of latency.
module my_fp_to_int #(
    parameter int unsigned OutWidth     = 32,
    parameter int unsigned ExpWidth     = 8,
    parameter int unsigned ManWidth     = 23,
    parameter int unsigned ExpConst     = 127,
    parameter bit          RoundNearest = 1'b0
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic [ExpWidth+ManWidth:0] InData_i,
    input  logic                       InDataVal_i,
    output logic [OutWidth-1:0]        OutData_o,
    output logic                       OutDataVal_o,
    output logic                       Ovf_o
);
    localparam int unsigned EW   = ExpWidth + 2;
    localparam int unsigned SW   = ManWidth + 1;
    localparam int unsigned RW   = 2 * ManWidth + 1;
    localparam int unsigned RShW = $clog2(ManWidth + 1);
    localparam int unsigned LShW = $clog2(OutWidth);

    localparam logic [OutWidth:0]   MaxPosMag = {2'b00, {(OutWidth-1){1'b1}}};
    localparam logic [OutWidth:0]   MinNegMag = {2'b01, {(OutWidth-1){1'b0}}};
    localparam logic [OutWidth-1:0] MaxInt    = {1'b0, {(OutWidth-1){1'b1}}};
    localparam logic [OutWidth-1:0] MinInt    = {1'b1, {(OutWidth-1){1'b0}}};

    // ---------------- Stage 1: unpack / classify ----------------
    logic                w_sign;
    logic [ExpWidth-1:0] w_exp;
    logic [ManWidth-1:0] w_man;
    logic signed [EW-1:0] w_e;
    logic                w_zero;
    logic                w_special;
    logic                w_small;
    logic                w_big;

    assign w_sign    = InData_i[ExpWidth+ManWidth];
    assign w_exp     = InData_i[ExpWidth+ManWidth-1:ManWidth];
    assign w_man     = InData_i[ManWidth-1:0];
    assign w_e       = signed'(EW'(w_exp) - EW'(ExpConst));
    assign w_zero    = (w_exp == '0);
    assign w_special = &w_exp;
    assign w_small   = (int'(w_e) < 0);
    assign w_big     = (int'(w_e) >= int'(OutWidth) - 1);

    logic                 r_s1_val;
    logic                 r_s1_sign;
    logic signed [EW-1:0] r_s1_e;
    logic [SW-1:0]        r_s1_sig;
    logic                 r_s1_zero;
    logic                 r_s1_inf;
    logic                 r_s1_nan;
    logic                 r_s1_small;
    logic                 r_s1_big;

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_s1_val   <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_e     <= '0;
            r_s1_sig   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_small <= 1'b0;
            r_s1_big   <= 1'b0;
        end else begin
            r_s1_val   <= InDataVal_i;
            r_s1_sign  <= w_sign;
            r_s1_e     <= w_e;
            r_s1_sig   <= {~w_zero, w_man};
            r_s1_zero  <= w_zero;
            r_s1_inf   <= w_special & (w_man == '0);
            r_s1_nan   <= w_special & (w_man != '0);
            r_s1_small <= w_small;
            r_s1_big   <= w_big;
        end
    end

    // ---------------- Stage 2: align ----------------
    logic [RShW-1:0]     w_rsh;
    logic [LShW-1:0]     w_lsh;
    logic [RW-1:0]       w_rvec;
    logic [OutWidth-1:0] w_lvec;
    logic                w_left;
    logic                w_ovr;
    logic [OutWidth-1:0] w_mag;
    logic                w_guard;
    logic                w_sticky;

    assign w_rsh  = RShW'(int'(ManWidth) - int'(r_s1_e));
    assign w_lsh  = LShW'(int'(r_s1_e) - int'(ManWidth));
    assign w_left = (int'(r_s1_e) >= int'(ManWidth));
    // e == OutWidth-1 still aligns exactly; only the most negative value survives it.
    assign w_ovr  = r_s1_big & (int'(r_s1_e) > int'(OutWidth) - 1);

    // Right shift keeps the shifted-out bits in the low ManWidth positions.
    always_comb begin
        w_rvec = {r_s1_sig, {ManWidth{1'b0}}};
        for (int k = 0; k < int'(RShW); k++) begin
            if (w_rsh[k]) begin
                w_rvec = w_rvec >> (32'd1 << k);
            end
        end
    end

    always_comb begin
        w_lvec = OutWidth'(r_s1_sig);
        for (int k = 0; k < int'(LShW); k++) begin
            if (w_lsh[k]) begin
                w_lvec = w_lvec << (32'd1 << k);
            end
        end
    end

    always_comb begin
        w_mag    = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        if (r_s1_small) begin
            w_guard  = (int'(r_s1_e) == -1);
            w_sticky = |r_s1_sig[ManWidth-1:0];
        end else if (w_left) begin
            w_mag = w_lvec;
        end else begin
            w_mag    = OutWidth'(w_rvec[RW-1:ManWidth]);
            w_guard  = w_rvec[ManWidth-1];
            w_sticky = |w_rvec[ManWidth-2:0];
        end
    end

    logic                r_s2_val;
    logic                r_s2_sign;
    logic [OutWidth-1:0] r_s2_mag;
    logic                r_s2_guard;
    logic                r_s2_sticky;
    logic                r_s2_zero;
    logic                r_s2_nan;
    logic                r_s2_sat;

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_s2_val    <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_mag    <= '0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_nan    <= 1'b0;
            r_s2_sat    <= 1'b0;
        end else begin
            r_s2_val    <= r_s1_val;
            r_s2_sign   <= r_s1_sign;
            r_s2_mag    <= w_mag;
            r_s2_guard  <= w_guard;
            r_s2_sticky <= w_sticky;
            r_s2_zero   <= r_s1_zero;
            r_s2_nan    <= r_s1_nan;
            r_s2_sat    <= r_s1_inf | w_ovr;
        end
    end

    // ---------------- Stage 3: round / sign / saturate ----------------
    logic                w_inc;
    logic [OutWidth:0]   w_rmag;
    logic                w_over;
    logic [OutWidth-1:0] w_res;
    logic                w_res_ovf;

    assign w_inc  = RoundNearest & r_s2_guard & (r_s2_sticky | r_s2_mag[0]);
    assign w_rmag = {1'b0, r_s2_mag} + (OutWidth+1)'(w_inc);
    assign w_over = r_s2_sign ? (w_rmag > MinNegMag) : (w_rmag > MaxPosMag);

    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        if (r_s2_nan) begin
            w_res     = MaxInt;
            w_res_ovf = 1'b1;
        end else if (r_s2_zero) begin
            w_res     = '0;
        end else if (r_s2_sat || w_over) begin
            w_res     = r_s2_sign ? MinInt : MaxInt;
            w_res_ovf = 1'b1;
        end else begin
            w_res     = r_s2_sign ? -w_rmag[OutWidth-1:0] : w_rmag[OutWidth-1:0];
        end
    end

    logic                r_out_val;
    logic [OutWidth-1:0] r_out_data;
    logic                r_out_ovf;

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_out_val  <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            r_out_val <= r_s2_val;
            if (r_s2_val) begin
                r_out_data <= w_res;
                r_out_ovf  <= w_res_ovf;
            end
        end
    end

    assign OutData_o    = r_out_data;
    assign OutDataVal_o = r_out_val;
    assign Ovf_o        = r_out_ovf;

endmodule

// File: tb/tb_my_fp_to_int.sv
// Randomized self-checking bench for my_fp_to_int; truncating and round-to-nearest
// instances share one input stream and are scored against an arithmetic model.
module tb_my_fp_to_int;

    typedef struct packed {
        logic        v;
        logic [31:0] dt;
        logic        ot;
        logic [31:0] dr;
        logic        orr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_val;
    logic [31:0] data_t, data_r;
    logic        val_t, val_r, ovf_t, ovf_r;

    int   n_checks;
    int   n_fail;
    exp_t q_exp[$];
    logic [31:0] held_dt, held_dr;
    logic        held_ot, held_or;

    my_fp_to_int #(.RoundNearest(1'b0)) u_dut_trunc (
        .Clk_i        (clk),
        .Rst_i        (rst),
        .InData_i     (in_data),
        .InDataVal_i  (in_val),
        .OutData_o    (data_t),
        .OutDataVal_o (val_t),
        .Ovf_o        (ovf_t)
    );

    my_fp_to_int #(.RoundNearest(1'b1)) u_dut_rne (
        .Clk_i        (clk),
        .Rst_i        (rst),
        .InData_i     (in_data),
        .InDataVal_i  (in_val),
        .OutData_o    (data_r),
        .OutDataVal_o (val_r),
        .Ovf_o        (ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value = sig * 2^(e-23) evaluated with plain integer arithmetic, then clamped.
    function automatic void ref_model(input logic [31:0] f, input bit rne,
                                      output logic [31:0] res, output logic ovf);
        int     ex;
        int     e;
        int     sh;
        longint sig, mag, q, rem, half, val;
        ex = int'(f[30:23]);
        if (ex == 0) begin
            res = 32'h0;
            ovf = 1'b0;
            return;
        end
        if (ex == 255) begin
            ovf = 1'b1;
            res = (f[22:0] != 0 || !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
            return;
        end
        e   = ex - 127;
        sig = longint'({1'b1, f[22:0]});
        if (e > 40) begin
            mag = 64'sd1 <<< 41;
        end else if (e >= 23) begin
            mag = sig <<< (e - 23);
        end else if (e < -1) begin
            mag = 0;
        end else begin
            sh   = 23 - e;
            q    = sig >>> sh;
            rem  = sig - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            mag  = q;
            if (rne && (rem > half || (rem == half && (q % 2) == 1))) mag = q + 1;
        end
        val = f[31] ? -mag : mag;
        if (val > 64'sd2147483647) begin
            res = 32'h7FFF_FFFF;
            ovf = 1'b1;
        end else if (val < -64'sd2147483648) begin
            res = 32'h8000_0000;
            ovf = 1'b1;
        end else begin
            res = val[31:0];
            ovf = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_float();
        int unsigned pick;
        logic [7:0]  ex;
        logic [22:0] man;
        pick = $urandom_range(0, 15);
        if (pick == 0)      ex = 8'h00;
        else if (pick == 1) ex = 8'hFF;
        else if (pick < 4)  ex = 8'($urandom);
        else                ex = 8'($urandom_range(120, 160));
        man = 23'($urandom);
        if ($urandom_range(0, 3) == 0) man = man & 23'h7F_0000;
        if ($urandom_range(0, 7) == 0) man = 23'h0;
        return {1'($urandom), ex, man};
    endfunction

    // One clock: score the word that entered three clocks ago, then drive the next one.
    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic [31:0] et, input logic ot,
                         input logic [31:0] er, input logic orr);
        exp_t e;
        exp_t n;
        @(negedge clk);
        if (q_exp.size() >= 3) begin
            e = q_exp.pop_front();
            check_eq("val_trunc", {31'h0, val_t}, {31'h0, e.v});
            check_eq("val_rne", {31'h0, val_r}, {31'h0, e.v});
            if (e.v) begin
                held_dt = e.dt;
                held_ot = e.ot;
                held_dr = e.dr;
                held_or = e.orr;
            end
            check_eq(e.v ? "data_trunc" : "hold_trunc", data_t, held_dt);
            check_eq(e.v ? "ovf_trunc" : "hold_ovf_trunc", {31'h0, ovf_t}, {31'h0, held_ot});
            check_eq(e.v ? "data_rne" : "hold_rne", data_r, held_dr);
            check_eq(e.v ? "ovf_rne" : "hold_ovf_rne", {31'h0, ovf_r}, {31'h0, held_or});
        end
        n.v   = v;
        n.dt  = et;
        n.ot  = ot;
        n.dr  = er;
        n.orr = orr;
        q_exp.push_back(n);
        in_val  = v;
        in_data = d;
    endtask

    task automatic send_model(input logic [31:0] d);
        logic [31:0] rt, rr;
        logic        ot, orr;
        ref_model(d, 1'b0, rt, ot);
        ref_model(d, 1'b1, rr, orr);
        cycle(1'b1, d, rt, ot, rr, orr);
    endtask

    task automatic idle();
        cycle(1'b0, 32'($urandom), 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic flush_expect();
        exp_t n;
        q_exp.delete();
        n = '0;
        repeat (3) q_exp.push_back(n);
        held_dt = 32'h0;
        held_dr = 32'h0;
        held_ot = 1'b0;
        held_or = 1'b0;
    endtask

    // {input, trunc result, trunc ovf, rne result, rne ovf}
    logic [97:0] directed [20] = '{
        {32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0},
        {32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 1'b0},
        {32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0},
        {32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0},
        {32'h0040_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0},
        {32'h3F00_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0},
        {32'h3FC0_0000, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0},
        {32'h4020_0000, 32'h0000_0002, 1'b0, 32'h0000_0002, 1'b0},
        {32'h3F40_0000, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0},
        {32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0},
        {32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1},
        {32'hCF00_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0},
        {32'hCF00_0001, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1},
        {32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1},
        {32'hFF80_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1},
        {32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1},
        {32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 32'h7FFF_FF80, 1'b0},
        {32'h3FE0_0000, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0},
        {32'hBF00_0001, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0},
        {32'h4B80_0001, 32'h0100_0002, 1'b0, 32'h0100_0002, 1'b0}
    };

    initial begin
        logic [97:0] row;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_val   = 1'b0;
        in_data  = 32'h0;
        #3;
        check_eq("rst_data_trunc", data_t, 32'h0);
        check_eq("rst_val_trunc", {31'h0, val_t}, 32'h0);
        check_eq("rst_ovf_trunc", {31'h0, ovf_t}, 32'h0);
        check_eq("rst_data_rne", data_r, 32'h0);
        check_eq("rst_val_rne", {31'h0, val_r}, 32'h0);
        check_eq("rst_ovf_rne", {31'h0, ovf_r}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        flush_expect();

        foreach (directed[i]) begin
            row = directed[i];
            cycle(1'b1, row[97:66], row[65:34], row[33], row[32:1], row[0]);
        end
        repeat (2) idle();

        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(0, 3) == 0) idle();
            send_model(rand_float());
        end

        // Leave a known nonzero result on the outputs, then reset with 3 words in flight.
        send_model(32'h3F80_0000);
        repeat (3) idle();
        send_model(32'h4000_0000);
        send_model(32'h4040_0000);
        send_model(32'h4080_0000);
        #2;
        rst    = 1'b1;
        in_val = 1'b0;
        #1;
        check_eq("async_rst_data_trunc", data_t, 32'h0);
        check_eq("async_rst_val_trunc", {31'h0, val_t}, 32'h0);
        check_eq("async_rst_data_rne", data_r, 32'h0);
        check_eq("async_rst_val_rne", {31'h0, val_r}, 32'h0);
        check_eq("async_rst_ovf_trunc", {31'h0, ovf_t}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flush_expect();
        repeat (4) idle();
        send_model(32'hC0E0_0000);
        repeat (5) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_fp_to_int.md
Name: my_fp_to_int

Overview:
- Pipelined converter from custom floating point (sign, ExpWidth exponent, ManWidth mantissa, hidden bit) to two's-complement signed integer.
- Inverse of the team's integer-to-float block; sits on the same valid-only streaming path (no back-pressure) and accepts one word per clock.
- Handles zero/denormal, Inf/NaN and out-of-range inputs, with saturation and an overflow flag.
- Rounding is truncate-toward-zero or round-to-nearest-even, chosen by parameter.

Parameters:
- OutWidth, 32, integer result width (≥ ManWidth+2).
- ExpWidth, 8, exponent field width.
- ManWidth, 23, stored mantissa width (hidden bit excluded).
- ExpConst, 127, exponent bias.
- RoundNearest, 0, 0 = truncate toward zero; 1 = round to nearest, ties to even.

Ports:
- Clk_i  in  1  clock, all logic on rising edge.
- Rst_i  in  1  reset, asynchronous, active-high.
- InData_i  in  1+ExpWidth+ManWidth  float input {sign, exp, man}.
- InDataVal_i  in  1  input qualifier.
- OutData_o  out  OutWidth  signed integer result.
- OutDataVal_o  out  1  result qualifier.
- Ovf_o  out  1  saturation/invalid flag, qualified by OutDataVal_o.

Behaviour:
- Reset (async, all pipeline registers): OutData_o=0, OutDataVal_o=0, Ovf_o=0, internal valid bits=0.
- Latency: exactly 3 clocks from InDataVal_i sampled high to OutDataVal_o high. Throughput is 1 per clock.
- Valid pipeline: the valid bit advances every clock regardless of data.
- OutData_o/Ovf_o update only when stage-3 valid=1, otherwise they hold their last value. OutDataVal_o follows stage-3 valid every clock.
- Stage 1 (unpack/classify), registered:
  - sign, e = exp − ExpConst as a signed ExpWidth+2-bit value, sig = {hidden, man}.
  - class flags: zero (exp==0; denormals are treated as zero), special (exp all ones: Inf when man==0, NaN otherwise), small (e<0), big (e ≥ OutWidth−1).
- Stage 2 (align), registered:
  - If e ≥ ManWidth: mag = sig << (e−ManWidth), guard=0, sticky=0.
  - Else: mag = sig >> (ManWidth−e); guard = first bit shifted out; sticky = OR of the remaining shifted-out bits.
  - small case: mag=0; guard=1 only when e==−1; sticky = OR of all lower sig bits.
  - Shift is a log2 barrel shifter; mag is OutWidth bits.
- Stage 3 (round/sign/saturate), registered:
  - RoundNearest=1: increment when guard & (sticky | mag[0]). RoundNearest=0: no increment.
  - The rounded magnitude is checked against the limits: ≤ 2^(OutWidth−1)−1 when positive, ≤ 2^(OutWidth−1) when negative.
  - Result = sign ? −mag : mag.
- Special results:
  - zero/denormal → 0, Ovf=0; −0 → 0.
  - NaN → 2^(OutWidth−1)−1, Ovf=1.
  - +Inf, or positive out of range (including rounding up past the limit) → 2^(OutWidth−1)−1, Ovf=1.
  - −Inf, or negative out of range → −2^(OutWidth−1), Ovf=1.
  - Exactly −2^(OutWidth−1) (sign=1, e=OutWidth−1, man=0) → 0x80..0, Ovf=0. This is representable, so it is not flagged.
- Boundary cases:
  - Back-to-back valid inputs produce back-to-back outputs in order.
  - Gaps in valid produce gaps in OutDataVal_o.
  - Reset asserted mid-stream drops all in-flight words immediately. First output after release comes 3 clocks after the next valid input.

Test Plan:
- 0x3F800000 (1.0), 0xC0200000 (−2.5), 0x00000000, 0x80000000 (−0), 0x00400000 (denormal), all with RoundNearest=0 → 1, −2 (0xFFFFFFFE), 0, 0, 0; Ovf=0; each output exactly 3 clocks after input.
- RoundNearest=1: 0x3F000000 (0.5) → 0; 0x3FC00000 (1.5) → 2; 0x40200000 (2.5) → 2; 0x3F400000 (0.75) → 1; 0xBFC00000 (−1.5) → −2.
- 0x4F000000 (2^31) → 0x7FFFFFFF with Ovf=1; 0xCF000000 (−2^31) → 0x80000000 with Ovf=0; 0xCF000001 → 0x80000000 with Ovf=1.
- 0x7F800000 (+Inf) → 0x7FFFFFFF, Ovf=1; 0xFF800000 (−Inf) → 0x80000000, Ovf=1; 0x7FC00000 (NaN) → 0x7FFFFFFF, Ovf=1.
- Stream of 1000 random valid floats with random valid gaps, compared against a reference model → results matched in order, gaps preserved, outputs held during invalid cycles.
- Assert Rst_i asynchronously while 3 words are in flight → outputs and valids go to 0 at once with no clock edge needed; the 3 words never appear; the next input appears 3 clocks after release.
